// File: rtl/ushift_pkg.sv
// ushift_pkg: mode and state encodings shared by the shift register and its next-value logic
package ushift_pkg;
  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_SHR  = 3'b001,
    M_SHL  = 3'b010,
    M_LOAD = 3'b011,
    M_ROR  = 3'b100,
    M_ROL  = 3'b101,
    M_ASR  = 3'b110,
    M_CLR  = 3'b111
  } mode_e;
  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_e;
  function automatic logic is_burst_mode(input logic [2:0] m);
    return m inside {M_SHR, M_SHL, M_ROR, M_ROL, M_ASR};
  endfunction
endpackage

// File: rtl/ushift_op.sv
// ushift_op: combinational next-value of the shift register for a given mode
module ushift_op
  import ushift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] nq
);
  always_comb begin
    nq = q;
    case (mode)
      M_SHR:   nq = {sin, q[WIDTH-1:1]};
      M_SHL:   nq = {q[WIDTH-2:0], sin};
      M_LOAD:  nq = pin;
      M_ROR:   nq = {q[0], q[WIDTH-1:1]};
      M_ROL:   nq = {q[WIDTH-2:0], q[WIDTH-1]};
      M_ASR:   nq = {q[WIDTH-1], q[WIDTH-1:1]};
      M_CLR:   nq = '0;
      default: nq = q;
    endcase
  end
endmodule

// File: rtl/ushift_reg_param.sv
// ushift_reg_param: universal shift register with counted burst operation
module ushift_reg_param
  import ushift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] pin,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);
  state_e           r_state;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_mode;
  logic             r_done;
  logic [2:0]       w_mode;
  logic [WIDTH-1:0] w_nq;
  // Inside a burst the latched mode drives the datapath; external mode is ignored
  assign w_mode = (r_state == S_BURST) ? r_mode : mode;
  ushift_op #(.WIDTH(WIDTH)) u_op (
    .q   (r_q),
    .mode(w_mode),
    .sin (sin),
    .pin (pin),
    .nq  (w_nq)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_mode  <= M_HOLD;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (burst_start && is_burst_mode(mode)) begin
          if (burst_len == '0) r_done <= 1'b1;
          else begin
            r_state <= S_BURST;
            r_cnt   <= burst_len;
            r_mode  <= mode;
          end
        end else if (en) r_q <= w_nq;
      end else if (en) begin
        r_q   <= w_nq;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
      end
    end
  end
  assign q        = r_q;
  assign sout_msb = r_q[WIDTH-1];
  assign sout_lsb = r_q[0];
  assign busy     = (r_state == S_BURST);
  assign done     = r_done;
endmodule

// File: tb/tb_ushift_reg_param.sv
// tb_ushift_reg_param: directed vectors with hand-computed expectations for ushift_reg_param
module tb_ushift_reg_param;
  logic       clk = 1'b0;
  logic       reset, en, sin, burst_start;
  logic [2:0] mode;
  logic [7:0] pin, burst_len, q;
  logic       sout_msb, sout_lsb, busy, done;
  int         n_vec = 0;
  int         n_bad = 0;
  int         n_busy;

  ushift_reg_param #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sin(sin), .pin(pin),
    .burst_start(burst_start), .burst_len(burst_len), .q(q),
    .sout_msb(sout_msb), .sout_lsb(sout_lsb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic e, input logic [2:0] m, input logic s, input logic [7:0] p,
                      input logic bs, input logic [7:0] bl);
    en = e; mode = m; sin = s; pin = p; burst_start = bs; burst_len = bl;
    @(posedge clk);
    @(negedge clk);
    if (busy) n_busy++;
  endtask

  task automatic check_st(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
    check({tag, ".q"}, q, eq);
    check({tag, ".busy"}, busy, eb);
    check({tag, ".done"}, done, ed);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = 3'b000; sin = 1'b0; pin = '0; burst_start = 1'b0; burst_len = '0;
    n_busy = 0;
    #3;
    check_st("reset", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step(1, 3'b011, 0, 8'hA5, 0, 0); check("load", q, 8'hA5);
    check("sout_msb", sout_msb, 1'b1);
    check("sout_lsb", sout_lsb, 1'b1);
    step(1, 3'b001, 1, 8'h00, 0, 0); check("shr", q, 8'hD2);
    check("sout_lsb0", sout_lsb, 1'b0);
    step(1, 3'b010, 0, 8'h00, 0, 0); check("shl", q, 8'hA4);
    step(0, 3'b010, 1, 8'h00, 0, 0); check("stall", q, 8'hA4);
    step(1, 3'b000, 1, 8'hFF, 0, 0); check("hold", q, 8'hA4);
    step(1, 3'b011, 0, 8'h81, 0, 0);
    step(1, 3'b101, 0, 8'h00, 0, 0); check("rol", q, 8'h03);
    step(1, 3'b011, 0, 8'h81, 0, 0);
    step(1, 3'b100, 0, 8'h00, 0, 0); check("ror1", q, 8'hC0);
    step(1, 3'b100, 0, 8'h00, 0, 0); check("ror2", q, 8'h60);
    step(1, 3'b011, 0, 8'h80, 0, 0);
    step(1, 3'b110, 0, 8'h00, 0, 0); check("asr", q, 8'hC0);
    step(1, 3'b110, 0, 8'h00, 0, 0); check("asr2", q, 8'hE0);
    step(1, 3'b011, 0, 8'h40, 0, 0);
    step(1, 3'b110, 1, 8'h00, 0, 0); check("asr_sin", q, 8'h20);
    step(1, 3'b111, 1, 8'hFF, 0, 0); check("clr", q, 8'h00);
    // Burst rotate right x3 from 0x01
    step(1, 3'b011, 0, 8'h01, 0, 0);
    step(1, 3'b100, 0, 8'h00, 1, 3); check_st("b3.acc", 8'h01, 1, 0);
    step(1, 3'b011, 0, 8'hFF, 1, 7); check_st("b3.1", 8'h80, 1, 0);
    step(1, 3'b000, 0, 8'h00, 0, 0); check_st("b3.2", 8'h40, 1, 0);
    step(1, 3'b000, 0, 8'h00, 0, 0); check_st("b3.3", 8'h20, 0, 1);
    step(1, 3'b000, 0, 8'h00, 0, 0); check_st("b3.post", 8'h20, 0, 0);
    // Burst rotate left x4 with two stalled cycles and an ignored restart
    step(1, 3'b011, 0, 8'h01, 0, 0);
    n_busy = 0;
    step(1, 3'b101, 0, 8'h00, 1, 4); check_st("b4.acc", 8'h01, 1, 0);
    step(1, 3'b000, 0, 8'h00, 0, 0); check_st("b4.1", 8'h02, 1, 0);
    step(0, 3'b000, 0, 8'h00, 0, 0); check_st("b4.s1", 8'h02, 1, 0);
    step(0, 3'b000, 0, 8'h00, 0, 0); check_st("b4.s2", 8'h02, 1, 0);
    step(1, 3'b001, 0, 8'h00, 1, 9); check_st("b4.2", 8'h04, 1, 0);
    step(1, 3'b000, 0, 8'h00, 0, 0); check_st("b4.3", 8'h08, 1, 0);
    step(1, 3'b000, 0, 8'h00, 0, 0); check_st("b4.4", 8'h10, 0, 1);
    check("b4.busy_cycles", n_busy, 6);
    // Zero-length burst and burst_start with a non-burst mode
    step(1, 3'b001, 1, 8'h00, 1, 0); check_st("len0", 8'h10, 0, 1);
    step(1, 3'b000, 0, 8'h00, 0, 0); check_st("len0.post", 8'h10, 0, 0);
    step(1, 3'b011, 0, 8'h5A, 1, 3); check_st("bs_load", 8'h5A, 0, 0);
    step(1, 3'b000, 0, 8'h00, 0, 0); check_st("bs_load.post", 8'h5A, 0, 0);
    // Asynchronous reset in the middle of a burst
    step(1, 3'b010, 1, 8'h00, 1, 5); check_st("br.acc", 8'h5A, 1, 0);
    step(1, 3'b000, 1, 8'h00, 0, 0); check_st("br.1", 8'hB5, 1, 0);
    #2 reset = 1'b1;
    #1 check_st("br.rst", 8'h00, 0, 0);
    @(negedge clk);
    check_st("br.rst_hold", 8'h00, 0, 0);
    reset = 1'b0;
    step(1, 3'b000, 0, 8'h00, 0, 0); check_st("br.idle", 8'h00, 0, 0);
    step(1, 3'b011, 0, 8'h3C, 0, 0); check_st("br.load", 8'h3C, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
